// File: rtl/ica_pkg.sv
// ica_pkg: shared widths, element index type and FSM state type for the FastICA iteration controller
package ica_pkg;
    localparam int W_WIDTH = 26;
    localparam int N_ELEM  = 16;
    typedef logic [3:0] idx_t;
    typedef enum logic [3:0] {
        IDLE, UPD_REQ, UPD_HI, UPD_LO, ERR_REQ, ERR_HI, ERR_LO, STREAM, DONE
    } state_t;
endpackage

// File: rtl/ica_w_stream.sv
// ica_w_stream: 16-entry W snapshot buffer streamed out one element per valid/ready handshake
module ica_w_stream
    import ica_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_load,
    input  logic [N_ELEM*W_WIDTH-1:0]   i_w_flat,
    input  logic                        i_ready,
    output logic signed [W_WIDTH-1:0]   o_w,
    output idx_t                        o_idx,
    output logic                        o_valid,
    output logic                        o_last
);
    logic [W_WIDTH-1:0] r_buf [N_ELEM];
    logic               r_valid;
    idx_t               r_idx;
    always_ff @(posedge i_clk) begin
        if (i_load)
            for (int k = 0; k < N_ELEM; k++) r_buf[k] <= i_w_flat[k*W_WIDTH +: W_WIDTH];
    end
    // index wraps back to 0 after the last element, ready for the next snapshot
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_idx   <= '0;
        end else if (r_valid && i_ready) begin
            r_valid <= (r_idx != idx_t'(N_ELEM - 1));
            r_idx   <= r_idx + idx_t'(1);
        end
    end
    assign o_last  = r_valid && i_ready && (r_idx == idx_t'(N_ELEM - 1));
    assign o_valid = r_valid;
    assign o_idx   = r_idx;
    assign o_w     = r_valid ? r_buf[r_idx] : '0;
endmodule

// File: rtl/ica_iter_ctrl.sv
// ica_iter_ctrl: FastICA iteration sequencer driving the update/error stage handshakes and streaming the final W
module ica_iter_ctrl
    import ica_pkg::*;
#(
    parameter int MAX_ITER     = 64,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                        clk_iter,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        en_update,
    input  logic                        update_busy,
    output logic                        en_error,
    input  logic                        error_busy,
    input  logic                        isConverge,
    input  logic [N_ELEM*W_WIDTH-1:0]   w_flat,
    output logic signed [W_WIDTH-1:0]   w_out,
    output logic [3:0]                  w_out_idx,
    output logic                        w_out_valid,
    input  logic                        w_out_ready,
    output logic [7:0]                  iter_cnt,
    output logic                        converged,
    output logic                        stall_err,
    output logic                        ica_busy,
    output logic                        done
);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    state_t        r_state;
    logic [TW-1:0] r_tmo;
    logic [7:0]    r_iter;
    logic          r_conv, r_stall, r_en_upd, r_en_err, r_busy, r_done;
    logic [7:0]    w_iter_nxt;
    logic          w_hi_busy, w_fin, w_last;
    assign w_iter_nxt = (r_iter == 8'hFF) ? r_iter : r_iter + 8'd1;
    assign w_hi_busy  = (r_state == UPD_HI) ? update_busy : error_busy;
    assign w_fin      = (r_state == ERR_LO) && !error_busy && (isConverge || w_iter_nxt == 8'(MAX_ITER));
    ica_w_stream u_stream (
        .i_clk    (clk_iter),
        .i_rst_n  (rst_n),
        .i_load   (w_fin),
        .i_w_flat (w_flat),
        .i_ready  (w_out_ready),
        .o_w      (w_out),
        .o_idx    (w_out_idx),
        .o_valid  (w_out_valid),
        .o_last   (w_last)
    );
    always_ff @(posedge clk_iter or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_tmo    <= '0;
            r_iter   <= '0;
            r_conv   <= 1'b0;
            r_stall  <= 1'b0;
            r_en_upd <= 1'b0;
            r_en_err <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_en_upd <= 1'b0;
            r_en_err <= 1'b0;
            case (r_state)
                IDLE, DONE: if (start) begin
                    r_state  <= UPD_REQ;
                    r_en_upd <= 1'b1;
                    r_iter   <= '0;
                    r_conv   <= 1'b0;
                    r_stall  <= 1'b0;
                    r_done   <= 1'b0;
                    r_busy   <= 1'b1;
                end
                UPD_REQ: r_state <= UPD_HI;
                ERR_REQ: r_state <= ERR_HI;
                UPD_HI, ERR_HI: begin
                    if (w_hi_busy) begin
                        r_state <= (r_state == UPD_HI) ? UPD_LO : ERR_LO;
                        r_tmo   <= '0;
                    end else if (r_tmo == TW'(BUSY_TIMEOUT - 1)) begin
                        r_state <= DONE;
                        r_tmo   <= '0;
                        r_stall <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                UPD_LO: if (!update_busy) begin
                    r_state  <= ERR_REQ;
                    r_en_err <= 1'b1;
                end
                ERR_LO: if (!error_busy) begin
                    r_iter <= w_iter_nxt;
                    r_conv <= isConverge;
                    if (w_fin) begin
                        r_state <= STREAM;
                    end else begin
                        r_state  <= UPD_REQ;
                        r_en_upd <= 1'b1;
                    end
                end
                STREAM: if (w_last) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign en_update = r_en_upd;
    assign en_error  = r_en_err;
    assign iter_cnt  = r_iter;
    assign converged = r_conv;
    assign stall_err = r_stall;
    assign ica_busy  = r_busy;
    assign done      = r_done;
endmodule

// File: tb/tb_ica_iter_ctrl.sv
// tb_ica_iter_ctrl: scoreboard bench with behavioural update/error stages and a valid/ready sink
module tb_ica_iter_ctrl;
    import ica_pkg::*;
    typedef struct { logic [3:0] idx; logic [25:0] val; } elem_t;
    typedef struct { int it; int cv; int st; int nu; int ne; int lat; } end_t;

    logic               clk_iter = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic               en_update, en_error, update_busy, error_busy, isConverge;
    logic [16*26-1:0]   w_flat = '0;
    logic signed [25:0] w_out;
    logic [3:0]         w_out_idx;
    logic               w_out_valid, w_out_ready;
    logic [7:0]         iter_cnt;
    logic               converged, stall_err, ica_busy, done;

    int    upd_lat = 0, upd_len = 1, err_lat = 0, err_len = 2, conv_at = 0, rdy_mode = 0;
    bit    err_never = 1'b0;
    int    vals [16];
    elem_t exp_w [$];
    end_t  exp_end [$];
    int    checks = 0, errors = 0;

    ica_iter_ctrl #(.MAX_ITER(4), .BUSY_TIMEOUT(16)) dut (
        .clk_iter(clk_iter), .rst_n(rst_n), .start(start),
        .en_update(en_update), .update_busy(update_busy),
        .en_error(en_error), .error_busy(error_busy), .isConverge(isConverge),
        .w_flat(w_flat), .w_out(w_out), .w_out_idx(w_out_idx),
        .w_out_valid(w_out_valid), .w_out_ready(w_out_ready),
        .iter_cnt(iter_cnt), .converged(converged), .stall_err(stall_err),
        .ica_busy(ica_busy), .done(done)
    );

    always #5 clk_iter = ~clk_iter;

    initial begin
        update_busy = 1'b0;
        forever begin
            @(negedge clk_iter);
            if (en_update) begin
                repeat (upd_lat) @(negedge clk_iter);
                update_busy = 1'b1;
                repeat (upd_len) @(negedge clk_iter);
                update_busy = 1'b0;
            end
        end
    end

    // error stage: reports isConverge=1 on pass number conv_at of the current run
    initial begin
        int pass;
        pass = 0;
        error_busy = 1'b0;
        isConverge = 1'b0;
        forever begin
            @(negedge clk_iter);
            isConverge = 1'b0;
            if (!ica_busy) pass = 0;
            if (en_error && !err_never) begin
                pass++;
                repeat (err_lat) @(negedge clk_iter);
                error_busy = 1'b1;
                repeat (err_len) @(negedge clk_iter);
                error_busy = 1'b0;
                isConverge = (pass == conv_at);
            end
        end
    end

    initial begin
        logic [3:0] rpat;
        int rcnt;
        rpat = 4'b1001;
        rcnt = 0;
        w_out_ready = 1'b1;
        forever begin
            @(negedge clk_iter);
            rcnt++;
            w_out_ready = (rdy_mode == 1) ? rpat[rcnt % 4] :
                          (rdy_mode == 2) ? !(w_out_valid && w_out_idx == 4'd7) : 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        logic       prev_vld, prev_rdy, prev_done, pend, eb1, eb2;
        logic [3:0] prev_idx;
        logic [25:0] prev_w;
        int  n_upd, n_err;
        time t_err;
        elem_t e;
        end_t  x;
        {prev_vld, prev_rdy, prev_done, pend, eb1, eb2} = '0;
        prev_idx = '0; prev_w = '0; n_upd = 0; n_err = 0; t_err = 0;
        forever begin
            @(negedge clk_iter or negedge rst_n);
            #1;
            if (!rst_n) begin
                chk("reset_outputs", {en_update, en_error, w_out, w_out_idx, w_out_valid,
                                      iter_cnt, converged, stall_err, ica_busy, done}, 64'd0);
                {prev_vld, prev_rdy, prev_done, pend, eb1, eb2} = '0;
            end else begin
                if (pend) begin
                    chk("start_clear", {iter_cnt, converged, stall_err, done, en_update, ica_busy},
                        {8'd0, 3'b000, 2'b11});
                    pend = 1'b0;
                end
                if (start && !ica_busy) begin
                    n_upd = 0;
                    n_err = 0;
                    pend  = 1'b1;
                end
                if (en_update) n_upd++;
                if (en_error) begin
                    n_err++;
                    t_err = $time;
                end
                if (prev_vld && !prev_rdy)
                    chk("hold_stable", {w_out_valid, w_out_idx, w_out}, {1'b1, prev_idx, prev_w});
                if (prev_vld && prev_rdy && prev_idx != 4'd15)
                    chk("no_bubble", {w_out_valid, w_out_idx}, {1'b1, prev_idx + 4'd1});
                if (w_out_valid && !prev_vld)
                    chk("stream_latency", {eb2, eb1}, 2'b10);
                if (w_out_valid && w_out_ready) begin
                    chk("elem_pending", 64'(exp_w.size() > 0), 64'd1);
                    if (exp_w.size() > 0) begin
                        e = exp_w.pop_front();
                        chk("elem", {w_out_idx, w_out}, {e.idx, e.val});
                    end
                end
                if (done && !prev_done) begin
                    chk("end_pending", 64'(exp_end.size() > 0), 64'd1);
                    if (exp_end.size() > 0) begin
                        x = exp_end.pop_front();
                        chk("end_state", {iter_cnt, converged, stall_err, ica_busy},
                            {8'(x.it), 1'(x.cv), 1'(x.st), 1'b0});
                        chk("pulse_counts", {16'(n_upd), 16'(n_err)}, {16'(x.nu), 16'(x.ne)});
                        chk("stream_drained", 64'(exp_w.size()), 64'd0);
                        if (x.lat >= 0) chk("stall_latency", 64'(($time - t_err) / 10), 64'(x.lat));
                    end
                end
                eb2 = eb1;
                eb1 = error_busy;
                prev_vld  = w_out_valid;
                prev_rdy  = w_out_ready;
                prev_idx  = w_out_idx;
                prev_w    = w_out;
                prev_done = done;
            end
        end
    end

    task automatic set_w(input int sel);
        for (int k = 0; k < 16; k++) begin
            int v;
            v = (sel == 0) ? (k - 8) * 2000000 + k :
                (sel == 1) ? ((k % 2 == 0) ? -33554432 + k * 3 : 33554431 - k * 5) : k * 1000 - 7000;
            vals[k] = v;
            w_flat[k*26 +: 26] = v[25:0];
        end
    endtask

    task automatic push_stream();
        for (int k = 0; k < 16; k++) exp_w.push_back('{idx: 4'(k), val: vals[k][25:0]});
    endtask

    task automatic kick();
        @(negedge clk_iter);
        start = 1'b1;
        @(negedge clk_iter);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && !done; i++) @(negedge clk_iter);
        if (!done) begin
            $display("FAIL done_timeout: done still 0 after 3000 cycles at %0t", $time);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
            $fatal(1);
        end
        repeat (2) @(negedge clk_iter);
    endtask

    task automatic run(input int conv, input int it, input int cv, input int st, input int nu,
                       input int ne, input int lat, input bit strm, input bit scramble, input bit stray);
        conv_at = conv;
        if (strm) push_stream();
        exp_end.push_back('{it, cv, st, nu, ne, lat});
        kick();
        if (stray) begin
            for (int i = 0; i < 500 && !error_busy; i++) @(posedge clk_iter);
            @(negedge clk_iter);
            start = 1'b1;
            @(negedge clk_iter);
            start = 1'b0;
        end
        if (scramble) begin
            for (int i = 0; i < 500 && !w_out_valid; i++) @(negedge clk_iter);
            w_flat = '1;
        end
        wait_done();
    endtask

    initial begin
        repeat (3) @(negedge clk_iter);
        rst_n = 1'b1;
        // converge on 3rd pass, zero-cycle update ack
        set_w(0); upd_lat = 0; upd_len = 3; err_lat = 2; err_len = 2;
        run(3, 3, 1, 0, 3, 3, -1, 1'b1, 1'b0, 1'b0);
        // never converges: capped at MAX_ITER=4, update ack on the last permitted wait cycle
        set_w(1); upd_lat = 16; upd_len = 1; err_lat = 0; err_len = 2;
        run(0, 4, 0, 0, 4, 4, -1, 1'b1, 1'b0, 1'b0);
        // error stage never acknowledges: stall abort, no stream
        upd_lat = 1; upd_len = 2; err_never = 1'b1;
        run(0, 0, 0, 1, 1, 1, 17, 1'b0, 1'b0, 1'b0);
        // ready pattern 1,0,0,1 and input W changed after the snapshot
        err_never = 1'b0; set_w(2); err_lat = 1; err_len = 1; rdy_mode = 1;
        run(1, 1, 1, 0, 1, 1, -1, 1'b1, 1'b1, 1'b0);
        // stray start in ERR_LO, then restart from DONE
        rdy_mode = 0; set_w(0); err_lat = 1; err_len = 3;
        run(2, 2, 1, 0, 2, 2, -1, 1'b1, 1'b0, 1'b1);
        run(1, 1, 1, 0, 1, 1, -1, 1'b1, 1'b0, 1'b0);
        // reset in the middle of the stream at element 7, then a clean run
        set_w(1); conv_at = 1; rdy_mode = 2;
        push_stream();
        kick();
        for (int i = 0; i < 500 && !(w_out_valid && w_out_idx == 4'd7); i++) @(negedge clk_iter);
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk_iter);
        rst_n = 1'b1;
        exp_w.delete();
        rdy_mode = 0;
        set_w(2);
        run(2, 2, 1, 0, 2, 2, -1, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk_iter);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
